json_motion_serializer: RTL and testbench

- Streams a robot motion command as ASCII JSON over a byte ready/valid interface into the existing uart_tx, format `{"T":<CMD_T>,"L":<l>,"R":<r>}\n`.
- Unlike the fixed-string table it supersedes, wheel speeds are arbitrary signed values formatted at run time.
- Adds a command handshake, heartbeat resend and an optional STOP-on-reset frame.
- Sits between the IR/remote decode logic and uart_tx.

---
 rtl/json_motion_pkg.sv | 39 +++
 rtl/speed_to_ascii.sv | 43 ++++
 rtl/json_motion_serializer.sv | 231 +++++++++++++++++++++++
 tb/tb_json_motion_serializer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/json_motion_pkg.sv
// json_motion_pkg
// Shared definitions for the JSON motion serializer: ASCII byte constants,
// the serializer state encoding, frame layout constants and the speed
// saturation helper used by the per-channel formatter.
// No ports (package).
package json_motion_pkg;

  localparam logic [7:0] LBRACE = 8'h7B;
  localparam logic [7:0] RBRACE = 8'h7D;
  localparam logic [7:0] QUOTE  = 8'h22;
  localparam logic [7:0] COLON  = 8'h3A;
  localparam logic [7:0] COMMA  = 8'h2C;
  localparam logic [7:0] MINUS  = 8'h2D;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] ZERO   = 8'h30;
  localparam logic [7:0] NL     = 8'h0A;

  // Bytes that appear in every frame regardless of the two speed values:
  // {"T":d,"L":  ,"R":  }  \n
  localparam int FIXED_BYTES = 18;

  // Largest magnitude that can be expressed (1.00 in hundredths)
  localparam int SPEED_LIMIT = 100;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    EMIT,
    GAP
  } state_t;

  // Saturate a signed speed in hundredths to [-SPEED_LIMIT, +SPEED_LIMIT]
  function automatic int sat_speed(input int value);
    if (value > SPEED_LIMIT) return SPEED_LIMIT;
    if (value < -SPEED_LIMIT) return -SPEED_LIMIT;
    return value;
  endfunction

endpackage

// File: rtl/speed_to_ascii.sv
// speed_to_ascii
// Combinational formatter for one wheel channel. Saturates the signed
// hundredths value and splits it into sign, integer digit and two fraction
// digits as ASCII characters.
// Ports:
//   speed      in  SPEED_W  signed speed in hundredths
//   neg        out 1        value (after saturation) is negative
//   sat        out 1        saturation changed the value
//   int_char   out 8        '0' or '1'
//   tenth_char out 8        tenths digit
//   hund_char  out 8        hundredths digit
module speed_to_ascii
  import json_motion_pkg::*;
#(
  parameter int SPEED_W = 8
)
(
  input  logic signed [SPEED_W-1:0] speed,
  output logic                      neg,
  output logic                      sat,
  output logic [7:0]                int_char,
  output logic [7:0]                tenth_char,
  output logic [7:0]                hund_char
);

  int clamped_value;
  int mag;
  int frac;

  always_comb begin
    clamped_value = sat_speed(int'(speed));
    sat           = (clamped_value != int'(speed));
    // Zero is never negative, so "-0.00" cannot be produced
    neg           = (clamped_value < 0);
    mag           = neg ? -clamped_value : clamped_value;
    // Only 100 carries into the integer digit; everything else is 0.xx
    frac          = (mag == SPEED_LIMIT) ? 0 : mag;
    int_char      = (mag == SPEED_LIMIT) ? (ZERO + 8'd1) : ZERO;
    tenth_char    = ZERO + 8'(frac / 10);
    hund_char     = ZERO + 8'(frac % 10);
  end

endmodule

// File: rtl/json_motion_serializer.sv
// json_motion_serializer
// Streams a motion command as ASCII JSON  {"T":<CMD_T>,"L":<l>,"R":<r>}\n
// one byte at a time over a ready/valid interface toward uart_tx. Handles
// the command handshake, a heartbeat resend of the last command and an
// optional STOP frame after reset.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   cmd_valid / cmd_ready  command handshake
//   left_speed/right_speed signed hundredths
//   tx_data/tx_valid/tx_ready  byte stream to the UART
//   busy                   CONVERT or EMIT in progress
//   frame_done             one-cycle pulse after the '\n' handshake
//   clamped                one-cycle pulse when an accepted command saturated
//   frame_count            completed frames, wraps
module json_motion_serializer
  import json_motion_pkg::*;
#(
  parameter int SPEED_W       = 8,
  parameter int CMD_T         = 1,
  parameter int RESEND_CYCLES = 25_000_000,
  parameter int STOP_ON_RESET = 1,
  parameter int CNT_W         = 16
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic signed [SPEED_W-1:0] left_speed,
  input  logic signed [SPEED_W-1:0] right_speed,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      clamped,
  output logic [CNT_W-1:0]          frame_count
);

  localparam int TIMER_W = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;

  state_t state, state_next;

  logic signed [SPEED_W-1:0] lat_l, lat_r;
  // Low only in the first cycle after reset; that cycle is reserved for the STOP frame
  logic armed;
  // Heartbeat and STOP frames never report clamping
  logic suppress_clamp;
  logic [TIMER_W-1:0] timer;
  logic [4:0] idx;

  logic       l_neg, r_neg;
  logic [7:0] l_int, l_tenth, l_hund, r_int, r_tenth, r_hund;

  logic       cl_neg, cl_sat, cr_neg, cr_sat;
  logic [7:0] cl_int, cl_tenth, cl_hund, cr_int, cr_tenth, cr_hund;

  logic start_cmd, start_stop, start_hb, start_any;
  logic [4:0] l_len, r_len, r_hdr, r_val, last_idx;
  logic last_byte;
  logic [7:0] byte_out;

  speed_to_ascii #(.SPEED_W(SPEED_W)) u_left (
    .speed      (lat_l),
    .neg        (cl_neg),
    .sat        (cl_sat),
    .int_char   (cl_int),
    .tenth_char (cl_tenth),
    .hund_char  (cl_hund)
  );

  speed_to_ascii #(.SPEED_W(SPEED_W)) u_right (
    .speed      (lat_r),
    .neg        (cr_neg),
    .sat        (cr_sat),
    .int_char   (cr_int),
    .tenth_char (cr_tenth),
    .hund_char  (cr_hund)
  );

  // ,"L":  /  ,"R":  header for a value field
  function automatic logic [7:0] header_char(input logic [4:0] k, input logic [7:0] letter);
    case (k)
      5'd0:    return COMMA;
      5'd1:    return QUOTE;
      5'd2:    return letter;
      5'd3:    return QUOTE;
      default: return COLON;
    endcase
  endfunction

  // Character k of  [-]i.th
  function automatic logic [7:0] value_char(input logic [4:0] k, input logic neg,
                                            input logic [7:0] i, input logic [7:0] t,
                                            input logic [7:0] h);
    logic [4:0] j;
    j = neg ? (k - 5'd1) : k;
    if (neg && (k == 5'd0)) return MINUS;
    case (j)
      5'd0:    return i;
      5'd1:    return DOT;
      5'd2:    return t;
      default: return h;
    endcase
  endfunction

  // Frame start arbitration: STOP after reset, then a new command, then heartbeat.
  // The heartbeat launches on the IDLE cycle in which the timer would reach RESEND_CYCLES.
  always_comb begin
    start_stop = (state == IDLE) && !armed && (STOP_ON_RESET != 0);
    start_cmd  = (state == IDLE) && armed && cmd_valid;
    start_hb   = (state == IDLE) && armed && !cmd_valid && (RESEND_CYCLES != 0) &&
                 (timer == TIMER_W'(RESEND_CYCLES - 1));
    start_any  = start_stop || start_cmd || start_hb;
  end

  // Variable frame layout: each value is 4 chars, 5 with a leading '-'
  always_comb begin
    l_len     = l_neg ? 5'd5 : 5'd4;
    r_len     = r_neg ? 5'd5 : 5'd4;
    r_hdr     = 5'd11 + l_len;
    r_val     = r_hdr + 5'd5;
    last_idx  = 5'(FIXED_BYTES - 1) + l_len + r_len;
    last_byte = (idx == last_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_any) state_next = CONVERT;
      CONVERT: state_next = EMIT;
      EMIT:    if (tx_ready && last_byte) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state == IDLE) && armed;
    busy       = (state == CONVERT) || (state == EMIT);
    frame_done = (state == GAP);
    tx_valid   = (state == EMIT);
    clamped    = (state == CONVERT) && !suppress_clamp && (cl_sat || cr_sat);
    tx_data    = tx_valid ? byte_out : 8'h00;
  end

  // Byte selected by idx within the current frame
  always_comb begin
    byte_out = NL;
    if (idx < 5'd5) begin
      case (idx)
        5'd0:    byte_out = LBRACE;
        5'd1:    byte_out = QUOTE;
        5'd2:    byte_out = "T";
        5'd3:    byte_out = QUOTE;
        default: byte_out = COLON;
      endcase
    end else if (idx == 5'd5) begin
      byte_out = ZERO + 8'(CMD_T);
    end else if (idx < 5'd11) begin
      byte_out = header_char(idx - 5'd6, "L");
    end else if (idx < r_hdr) begin
      byte_out = value_char(idx - 5'd11, l_neg, l_int, l_tenth, l_hund);
    end else if (idx < r_val) begin
      byte_out = header_char(idx - r_hdr, "R");
    end else if (idx < (r_val + r_len)) begin
      byte_out = value_char(idx - r_val, r_neg, r_int, r_tenth, r_hund);
    end else if (idx < last_idx) begin
      byte_out = RBRACE;
    end
  end

  // Latched command, digit registers, byte index, resend timer and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed          <= 1'b0;
      suppress_clamp <= 1'b0;
      lat_l          <= '0;
      lat_r          <= '0;
      timer          <= '0;
      idx            <= '0;
      l_neg          <= 1'b0;
      r_neg          <= 1'b0;
      l_int          <= ZERO;
      l_tenth        <= ZERO;
      l_hund         <= ZERO;
      r_int          <= ZERO;
      r_tenth        <= ZERO;
      r_hund         <= ZERO;
      frame_count    <= '0;
    end else begin
      armed <= 1'b1;

      if (start_cmd) begin
        lat_l          <= left_speed;
        lat_r          <= right_speed;
        suppress_clamp <= 1'b0;
      end else if (start_stop) begin
        lat_l          <= '0;
        lat_r          <= '0;
        suppress_clamp <= 1'b1;
      end else if (start_hb) begin
        suppress_clamp <= 1'b1;
      end

      if (start_any) timer <= '0;
      else if ((state == IDLE) && (RESEND_CYCLES != 0)) timer <= timer + TIMER_W'(1);

      if (state == CONVERT) begin
        idx     <= '0;
        l_neg   <= cl_neg;
        l_int   <= cl_int;
        l_tenth <= cl_tenth;
        l_hund  <= cl_hund;
        r_neg   <= cr_neg;
        r_int   <= cr_int;
        r_tenth <= cr_tenth;
        r_hund  <= cr_hund;
      end else if ((state == EMIT) && tx_ready) begin
        idx <= idx + 5'd1;
        if (last_byte) frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_json_motion_serializer.sv
// tb_json_motion_serializer
// Directed self-checking bench for json_motion_serializer. Frames are
// compared byte by byte against hand-written JSON strings; handshake
// timing, pulses and the frame counter are checked at fixed points.
// Ports: none (top-level bench).
module tb_json_motion_serializer;

  localparam int RESEND = 100;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic signed [7:0] left_speed;
  logic signed [7:0] right_speed;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              frame_done;
  logic              clamped;
  logic [15:0]       frame_count;

  int errors = 0;
  int checks = 0;

  json_motion_serializer #(
    .SPEED_W       (8),
    .CMD_T         (1),
    .RESEND_CYCLES (RESEND),
    .STOP_ON_RESET (1),
    .CNT_W         (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .left_speed  (left_speed),
    .right_speed (right_speed),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frame_done  (frame_done),
    .clamped     (clamped),
    .frame_count (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present a command from a negedge and hold it until the accepting posedge
  task automatic apply_stimulus(input int l, input int r, input int budget);
    int waited;
    waited      = 0;
    cmd_valid   = 1'b1;
    left_speed  = 8'(l);
    right_speed = 8'(r);
    while (!cmd_ready && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check_output("cmd accepted within budget", 32'(waited < budget), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Receive up to max_bytes of a frame, driving tx_ready once every 'period'
  // valid cycles, and compare each handshaked byte to exp.
  task automatic collect_frame(input string exp, input int period, input int max_bytes,
                               output int first_n, output int last_n,
                               output int unstable, output int ready_seen);
    int pos, n, phase, lim, budget;
    logic [7:0] held;
    logic have_held;
    pos = 0; n = 0; phase = 0; have_held = 1'b0;
    first_n = -1; last_n = -1; unstable = 0; ready_seen = 0;
    lim    = (max_bytes < exp.len()) ? max_bytes : exp.len();
    budget = (lim + 2) * (period + 1) + 10;
    while (pos < lim && n < budget) begin
      @(negedge clk);
      n++;
      if (cmd_ready) ready_seen++;
      if (tx_valid) begin
        if (first_n < 0) first_n = n;
        if (have_held && (tx_data !== held)) unstable++;
        tx_ready = (period <= 1) || (phase == period - 1);
        phase    = (phase == period - 1) ? 0 : phase + 1;
        if (tx_ready) begin
          check_output($sformatf("frame byte %0d", pos), tx_data, 32'(exp[pos]));
          pos++;
          last_n    = n;
          have_held = 1'b0;
        end else begin
          held      = tx_data;
          have_held = 1'b1;
        end
      end else begin
        tx_ready = (period <= 1);
      end
    end
    check_output("bytes handshaked", pos, lim);
  endtask

  initial begin
    string stop_frame, f1, f2, f3a, f3b, f5;
    int first_n, last_n, unstable, ready_seen, k, clamp_seen;

    stop_frame = "{\"T\":1,\"L\":0.00,\"R\":0.00}\n";
    f1  = "{\"T\":1,\"L\":0.10,\"R\":0.10}\n";
    f2  = "{\"T\":1,\"L\":-0.10,\"R\":-1.00}\n";
    f3a = "{\"T\":1,\"L\":1.00,\"R\":-0.05}\n";
    f3b = "{\"T\":1,\"L\":0.50,\"R\":-1.00}\n";
    f5  = "{\"T\":1,\"L\":-0.05,\"R\":1.00}\n";

    rst = 1'b1; cmd_valid = 1'b0; left_speed = '0; right_speed = '0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset cmd_ready", cmd_ready, 0);
    check_output("reset tx_valid", tx_valid, 0);
    check_output("reset tx_data", tx_data, 0);
    check_output("reset busy", busy, 0);
    check_output("reset frame_done", frame_done, 0);
    check_output("reset clamped", clamped, 0);
    check_output("reset frame_count", frame_count, 0);

    // STOP frame follows reset release without any command
    rst = 1'b0;
    @(negedge clk);
    check_output("stop convert busy", busy, 1);
    check_output("stop convert tx_valid", tx_valid, 0);
    check_output("stop convert clamped", clamped, 0);
    collect_frame(stop_frame, 1, 64, first_n, last_n, unstable, ready_seen);
    check_output("stop first byte latency", first_n, 1);
    @(negedge clk);
    check_output("stop gap frame_done", frame_done, 1);
    check_output("stop gap busy", busy, 0);
    check_output("stop gap cmd_ready", cmd_ready, 0);
    check_output("stop frame_count", frame_count, 1);
    @(negedge clk);
    check_output("idle frame_done", frame_done, 0);
    check_output("idle cmd_ready", cmd_ready, 1);

    // L=10,R=10 back-to-back: tx_valid appears two cycles after the accept cycle
    apply_stimulus(10, 10, 20);
    @(negedge clk);
    check_output("f1 convert busy", busy, 1);
    check_output("f1 convert cmd_ready", cmd_ready, 0);
    check_output("f1 convert tx_valid", tx_valid, 0);
    check_output("f1 convert clamped", clamped, 0);
    collect_frame(f1, 1, 64, first_n, last_n, unstable, ready_seen);
    check_output("f1 first byte latency", first_n, 1);
    check_output("f1 consecutive span", last_n - first_n + 1, 26);
    @(negedge clk);
    check_output("f1 frame_done", frame_done, 1);
    check_output("f1 frame_count", frame_count, 2);

    // Negative values and -128 saturating to -1.00
    @(negedge clk);
    apply_stimulus(-10, -128, 20);
    @(negedge clk);
    check_output("f2 clamped pulse", clamped, 1);
    collect_frame(f2, 1, 64, first_n, last_n, unstable, ready_seen);
    check_output("f2 consecutive span", last_n - first_n + 1, 28);
    @(negedge clk);
    check_output("f2 gap clamped", clamped, 0);
    check_output("f2 frame_done", frame_done, 1);
    check_output("f2 frame_count", frame_count, 3);

    // Slow UART; a second command is held during the frame and must stall
    @(negedge clk);
    apply_stimulus(100, -5, 20);
    @(negedge clk);
    check_output("f3a +100 not clamped", clamped, 0);
    cmd_valid = 1'b1; left_speed = 8'sd50; right_speed = -8'sd100;
    collect_frame(f3a, 434, 64, first_n, last_n, unstable, ready_seen);
    check_output("f3a tx_data stable while waiting", unstable, 0);
    check_output("f3a cmd_ready during frame", ready_seen, 0);
    @(negedge clk);
    check_output("f3a gap cmd_ready", cmd_ready, 0);
    check_output("f3a frame_count", frame_count, 4);
    @(negedge clk);
    check_output("f3b held cmd sees ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check_output("f3b convert busy", busy, 1);
    check_output("f3b -100 not clamped", clamped, 0);
    collect_frame(f3b, 1, 64, first_n, last_n, unstable, ready_seen);
    check_output("f3b consecutive span", last_n - first_n + 1, 27);
    @(negedge clk);
    check_output("f3b frame_done", frame_done, 1);
    check_output("f3b frame_count", frame_count, 5);

    // Heartbeat: 100 IDLE cycles after frame_done the last frame repeats
    k = 0; clamp_seen = 0;
    while (!busy && k < 400) begin
      @(negedge clk);
      k++;
      if (clamped) clamp_seen++;
    end
    check_output("heartbeat start delay", k, RESEND + 1);
    check_output("heartbeat clamped", clamp_seen, 0);
    collect_frame(f3b, 1, 64, first_n, last_n, unstable, ready_seen);
    @(negedge clk);
    check_output("heartbeat frame_count", frame_count, 6);

    // Reset while byte 12 is on the bus, then only a clean STOP frame follows
    @(negedge clk);
    apply_stimulus(-5, 100, 20);
    @(negedge clk);
    collect_frame(f5, 1, 12, first_n, last_n, unstable, ready_seen);
    @(negedge clk);
    check_output("byte 12 presented", tx_valid, 1);
    check_output("byte 12 value", tx_data, 32'(f5[12]));
    rst = 1'b1;
    #1;
    check_output("mid-frame reset tx_valid", tx_valid, 0);
    check_output("mid-frame reset tx_data", tx_data, 0);
    check_output("mid-frame reset busy", busy, 0);
    check_output("mid-frame reset frame_count", frame_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("post-reset stop busy", busy, 1);
    collect_frame(stop_frame, 1, 64, first_n, last_n, unstable, ready_seen);
    check_output("post-reset stop latency", first_n, 1);
    @(negedge clk);
    check_output("post-reset frame_done", frame_done, 1);
    check_output("post-reset frame_count", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
